// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the RAM port arbiter, its two requesters and the RAM.
// master = requesters + RAM side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_ack, vid_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_ack, vid_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// and the video reader; each access runs IDLE -> ISSUE -> WAIT -> RESP.
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input logic                 clk,
    input logic                 reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          owner_r, owner_s;
    logic          last_r, last_s;
    logic          we_r, we_s;
    logic [AW-1:0] addr_r, addr_s;
    logic [DW-1:0] wdata_r, wdata_s;
    logic [DW-1:0] cpu_rdata_r, cpu_rdata_s;
    logic [DW-1:0] vid_rdata_r, vid_rdata_s;
    logic          mem_en_r, mem_en_s;
    logic          mem_we_r, mem_we_s;
    logic          busy_r, busy_s;
    logic          cpu_ack_r, cpu_ack_s;
    logic          vid_ack_r, vid_ack_s;

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        last_s      = last_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        cpu_rdata_s = cpu_rdata_r;
        vid_rdata_s = vid_rdata_r;

        case (state_r)
            IDLE: begin
                // last_r = 1 means video won last, so the CPU takes a contended grant
                if (bus.cpu_req && (!bus.vid_req || last_r)) begin
                    owner_s = 1'b0;
                    we_s    = bus.cpu_we;
                    addr_s  = bus.cpu_addr;
                    wdata_s = bus.cpu_wdata;
                    state_s = ISSUE;
                end else if (bus.vid_req) begin
                    owner_s = 1'b1;
                    we_s    = 1'b0;
                    addr_s  = bus.vid_addr;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
                cnt_s   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_r == '0) begin
                    state_s = RESP;
                    if (!we_r && owner_r) begin
                        vid_rdata_s = bus.mem_rdata;
                    end else if (!we_r) begin
                        cpu_rdata_s = bus.mem_rdata;
                    end else begin
                        cpu_rdata_s = cpu_rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r - CW'(1'b1);
                end
            end
            RESP: begin
                state_s = IDLE;
                last_s  = owner_r;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        mem_en_s  = (state_s == ISSUE);
        mem_we_s  = (state_s == ISSUE) && we_s;
        busy_s    = (state_s != IDLE);
        cpu_ack_s = (state_s == RESP) && !owner_s;
        vid_ack_s = (state_s == RESP) && owner_s;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            cpu_rdata_r <= '0;
            vid_rdata_r <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            cpu_ack_r   <= 1'b0;
            vid_ack_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            cpu_rdata_r <= cpu_rdata_s;
            vid_rdata_r <= vid_rdata_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            busy_r      <= busy_s;
            cpu_ack_r   <= cpu_ack_s;
            vid_ack_r   <= vid_ack_s;
        end
    end

    assign bus.cpu_ack   = cpu_ack_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.vid_ack   = vid_ack_r;
    assign bus.vid_rdata = vid_rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;
endmodule
